mfft_combine_scheduler: RTL

Sequences the final radix-2 combine stage of the split FFT. It waits until both half-size sub-FFTs (even "chet" and odd "Nchet") have finished and hold their results. It then reads the NFFT/2 bin pairs, drives the twiddle multiplier enable and phase index, and tracks the multiplier and summer pipeline latency. It issues write strobes and addresses for output bins k and k+NFFT/2, then releases both sub-FFT buffers.

---
 rtl/mfft_combine_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mfft_combine_scheduler.sv
// Final radix-2 combine sequencer: waits for both half-size sub-FFTs, streams the
// HALF bin pairs through the twiddle multiplier/summer pipeline, then releases both buffers.
module mfft_combine_scheduler #(
    parameter int SIZE_BUFFER  = 6,
    parameter int MULT_LATENCY = 4,
    parameter int SUMM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   flag_complete_chet,
    input  logic                   flag_complete_Nchet,
    input  logic                   hold,
    output logic                   rd_en,
    output logic [SIZE_BUFFER-2:0] rd_addr,
    output logic                   en_mult,
    output logic [15:0]            phi,
    output logic                   wr_en,
    output logic [SIZE_BUFFER-1:0] wr_addr_lo,
    output logic [SIZE_BUFFER-1:0] wr_addr_hi,
    output logic                   ack_chet,
    output logic                   ack_Nchet,
    output logic                   busy,
    output logic                   done,
    output logic                   err_start,
    output logic [2:0]             dbg_state
);
    localparam int AW   = SIZE_BUFFER - 1;
    localparam int HALF = 1 << AW;
    localparam int PIPE = 1 + MULT_LATENCY + SUMM_LATENCY;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   rdy_c_q, rdy_c_d;
    logic                   rdy_n_q, rdy_n_d;
    logic [AW-1:0]          k_q, k_d;
    logic [SIZE_BUFFER-1:0] wr_cnt_q, wr_cnt_d;
    logic [PIPE-1:0]        vld_q, vld_d;
    logic [AW-1:0]          idx_q [PIPE];
    logic [AW-1:0]          idx_d [PIPE];
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   issue;

    // Read issue follows hold in the same cycle, so it is decoded from state rather than registered.
    assign issue = (state_q == S_RUN) && !hold;

    always_comb begin
        state_d  = state_q;
        rdy_c_d  = rdy_c_q;
        rdy_n_d  = rdy_n_q;
        k_d      = k_q;
        wr_cnt_d = wr_cnt_q + {{(SIZE_BUFFER-1){1'b0}}, vld_q[PIPE-1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WAIT;
                    rdy_c_d  = flag_complete_chet;
                    rdy_n_d  = flag_complete_Nchet;
                    k_d      = '0;
                    wr_cnt_d = '0;
                end
            end
            S_WAIT: begin
                rdy_c_d = rdy_c_q | flag_complete_chet;
                rdy_n_d = rdy_n_q | flag_complete_Nchet;
                if (rdy_c_d && rdy_n_d) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    k_d = k_q + 1'b1;
                    if (k_q == AW'(HALF - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wr_cnt_d == SIZE_BUFFER'(HALF)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rdy_c_d = 1'b0;
                rdy_n_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Free-running shift: hold only gates new issues, never in-flight pairs.
        vld_d[0] = issue;
        idx_d[0] = k_q;
        for (int i = 1; i < PIPE; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
        err_d  = start && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rdy_c_q  <= 1'b0;
            rdy_n_q  <= 1'b0;
            k_q      <= '0;
            wr_cnt_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < PIPE; i++) begin
                idx_q[i] <= '0;
            end
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_c_q  <= rdy_c_d;
            rdy_n_q  <= rdy_n_d;
            k_q      <= k_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
            for (int i = 0; i < PIPE; i++) begin
                idx_q[i] <= idx_d[i];
            end
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign rd_en      = issue;
    assign rd_addr    = issue ? k_q : '0;
    assign en_mult    = vld_q[0];
    assign phi        = vld_q[0] ? 16'(idx_q[0]) : 16'd0;
    assign wr_en      = vld_q[PIPE-1];
    assign wr_addr_lo = vld_q[PIPE-1] ? {1'b0, idx_q[PIPE-1]} : '0;
    assign wr_addr_hi = vld_q[PIPE-1] ? {1'b1, idx_q[PIPE-1]} : '0;
    assign done       = done_q;
    assign ack_chet   = done_q;
    assign ack_Nchet  = done_q;
    assign busy       = busy_q;
    assign err_start  = err_q;
    assign dbg_state  = state_q;
endmodule
